// File: rtl/f_stage_sched.sv
// f_stage_sched: two-requester round-robin frame scheduler for a shared F-stage row with a tag pipeline; F_SCHED_TIMEOUT_EN adds a stall abort
module f_stage_sched #(
  parameter int DW = 12,
  parameter int FRAME_LEN = 8,
  parameter int LAT = 2,
  parameter int TIMEOUT = 16,
  localparam int IW = $clog2(FRAME_LEN)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ0_VALID,
  input  logic [DW-1:0] REQ0_DATA,
  output logic          REQ0_READY,
  input  logic          REQ1_VALID,
  input  logic [DW-1:0] REQ1_DATA,
  output logic          REQ1_READY,
  output logic [DW-1:0] STAGE_IN,
  output logic          STAGE_EN,
  output logic          OUT_VALID,
  output logic          OUT_ID,
  output logic [IW-1:0] OUT_IDX,
  output logic          OUT_LAST,
  output logic          FRAME_DONE,
  output logic          ABORT
);
  localparam int TW = IW + 3;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t state, state_nx;
  logic pri, pri_nx, gnt, gnt_nx, acc, last, tags_busy;
  logic [IW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tag [LAT];
  assign REQ0_READY = state == BUSY && !gnt;
  assign REQ1_READY = state == BUSY && gnt;
  assign acc = state == BUSY && (gnt ? REQ1_VALID : REQ0_VALID);
  assign last = cnt == IW'(FRAME_LEN - 1);
  assign STAGE_EN = acc;
  assign STAGE_IN = acc ? (gnt ? REQ1_DATA : REQ0_DATA) : '0;
  assign {OUT_VALID, OUT_ID, OUT_IDX, OUT_LAST} = tag[LAT-1];
  assign FRAME_DONE = OUT_VALID & OUT_LAST;
`ifdef F_SCHED_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall;
  assign ABORT = state == BUSY && !acc && stall == SW'(TIMEOUT - 1);
  // consecutive BUSY cycles without an accept
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) stall <= '0;
    else stall <= (state == BUSY && !acc && !ABORT) ? stall + SW'(1) : '0;
`else
  assign ABORT = TIMEOUT < 0;
`endif
  // any tag still in flight ahead of the output stage keeps DRAIN busy
  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < LAT - 1; i++) tags_busy = tags_busy | tag[i][TW-1];
  end
  // next state, grant, priority pointer and in-frame sample counter
  always_comb begin
    state_nx = state;
    gnt_nx = gnt;
    pri_nx = pri;
    cnt_nx = cnt;
    case (state)
      IDLE: if (REQ0_VALID || REQ1_VALID) begin
        state_nx = BUSY;
        gnt_nx = (REQ0_VALID && REQ1_VALID) ? pri : REQ1_VALID;
        cnt_nx = '0;
      end
      BUSY: begin
        cnt_nx = acc ? cnt + IW'(1) : cnt;
        if (acc ? last : ABORT) begin
          state_nx = DRAIN;
          pri_nx = ~gnt;
        end
      end
      DRAIN: state_nx = tags_busy ? DRAIN : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // control registers
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      pri <= 1'b0;
      gnt <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      pri <= pri_nx;
      gnt <= gnt_nx;
      cnt <= cnt_nx;
    end
  // tag pipeline {valid, id, idx, last} tracking the stage latency
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      for (int i = 0; i < LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= acc ? {1'b1, gnt, cnt, last} : '0;
      for (int i = 1; i < LAT; i++) tag[i] <= tag[i-1];
    end
endmodule

// File: tb/tb_f_stage_sched.sv
// tb_f_stage_sched: scoreboard bench for f_stage_sched with directed frames
module tb_f_stage_sched;
  localparam int DW = 12;
  localparam int FL = 8;
  localparam int LAT = 2;
  localparam int IW = $clog2(FL);
`ifdef F_SCHED_TIMEOUT_EN
  localparam int EXP_ABORTS = 1;
`else
  localparam int EXP_ABORTS = 0;
`endif
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic [DW-1:0] REQ0_DATA = '0, REQ1_DATA = '0;
  logic REQ0_READY, REQ1_READY, STAGE_EN, OUT_VALID, OUT_ID, OUT_LAST, FRAME_DONE, ABORT;
  logic [DW-1:0] STAGE_IN;
  logic [IW-1:0] OUT_IDX;
  int q0[$], q1[$];
  logic [DW-1:0] exp_d[$];
  logic [IW+1:0] exp_t[$];
  int acc_cyc[$], stg_cyc[$];
  int cyc = 0, checks = 0, errors = 0, aborts = 0, abort_cyc = 0, done_cyc = 0;
  logic pop0 = 1'b0, pop1 = 1'b0;
  logic [IW+1:0] mon_t;
  f_stage_sched dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
    .STAGE_IN(STAGE_IN), .STAGE_EN(STAGE_EN),
    .OUT_VALID(OUT_VALID), .OUT_ID(OUT_ID), .OUT_IDX(OUT_IDX), .OUT_LAST(OUT_LAST),
    .FRAME_DONE(FRAME_DONE), .ABORT(ABORT)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask
  // queue a frame for requester r with data base+1..base+FL; three idle cycles before index gap
  task automatic frame(input int r, input int base, input int gap);
    for (int i = 0; i < FL; i++) begin
      if (i == gap) repeat (3) if (r == 0) q0.push_back(-1); else q1.push_back(-1);
      if (r == 0) q0.push_back(base + i + 1); else q1.push_back(base + i + 1);
      exp_d.push_back(DW'(base + i + 1));
      exp_t.push_back({r[0], IW'(i), i == FL - 1});
    end
  endtask
  task automatic wait_drain(input string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_t.size() > 0 || exp_d.size() > 0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk(name, n < 300, 1);
    repeat (6) @(negedge CLK);
    chk({name, "_idle"}, {REQ0_READY, REQ1_READY}, 0);
  endtask
  // requester 0 source: -1 entries are single idle cycles
  always begin
    @(negedge CLK);
    #2;
    if (pop0 && q0.size() > 0) void'(q0.pop_front());
    REQ0_VALID = q0.size() > 0 && q0[0] >= 0;
    REQ0_DATA = REQ0_VALID ? DW'(q0[0]) : '0;
    #1 pop0 = (q0.size() > 0 && q0[0] < 0) || (REQ0_VALID && REQ0_READY && RESET);
  end
  // requester 1 source
  always begin
    @(negedge CLK);
    #2;
    if (pop1 && q1.size() > 0) void'(q1.pop_front());
    REQ1_VALID = q1.size() > 0 && q1[0] >= 0;
    REQ1_DATA = REQ1_VALID ? DW'(q1[0]) : '0;
    #1 pop1 = (q1.size() > 0 && q1[0] < 0) || (REQ1_VALID && REQ1_READY && RESET);
  end
  // monitor: stage input and labelled outputs against the scoreboard
  always begin
    @(negedge CLK);
    #4;
    if (RESET) begin
      chk("ready_excl", {31'd0, REQ0_READY & REQ1_READY}, 0);
      if (ABORT) begin
        aborts++;
        abort_cyc = cyc;
      end
      if (STAGE_EN) begin
        acc_cyc.push_back(cyc);
        stg_cyc.push_back(cyc);
        chk("stage_pending", exp_d.size() > 0, 1);
        if (exp_d.size() > 0) chk("stage_in", STAGE_IN, exp_d.pop_front());
      end
      if (OUT_VALID) begin
        chk("out_pending", exp_t.size() > 0, 1);
        if (exp_t.size() > 0) begin
          mon_t = exp_t.pop_front();
          chk("out_tag", {OUT_ID, OUT_IDX, OUT_LAST}, mon_t);
          chk("frame_done", FRAME_DONE, mon_t[0]);
        end
        if (stg_cyc.size() > 0) chk("out_lat", cyc - stg_cyc.pop_front(), LAT);
        if (FRAME_DONE) done_cyc = cyc;
      end else chk("done_quiet", FRAME_DONE, 0);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int p, n;
    q0.push_back(-1);
    frame(0, 'h000, -1);
    frame(1, 'h100, -1);
    repeat (3) begin
      @(negedge CLK);
      #4;
      chk("rst_out", {OUT_VALID, OUT_ID, OUT_IDX, OUT_LAST, FRAME_DONE, ABORT, STAGE_EN, STAGE_IN, REQ0_READY, REQ1_READY}, 0);
    end
    @(negedge CLK);
    RESET = 1'b1;
    wait_drain("t1_drain");
    acc_cyc.delete();
    frame(0, 'h010, -1);
    frame(1, 'h110, -1);
    frame(0, 'h020, -1);
    wait_drain("rr_drain");
    chk("rr_count", acc_cyc.size(), 24);
    chk("rr_burst", acc_cyc[7] - acc_cyc[0], 7);
    chk("rr_turn01", acc_cyc[8] - acc_cyc[7], 4);
    chk("rr_turn12", acc_cyc[16] - acc_cyc[15], 4);
    acc_cyc.delete();
    frame(1, 'h200, 4);
    wait_drain("bub_drain");
    chk("bub_run", acc_cyc[3] - acc_cyc[0], 3);
    chk("bub_gap", acc_cyc[4] - acc_cyc[3], 4);
    chk("bub_tail", acc_cyc[7] - acc_cyc[4], 3);
    acc_cyc.delete();
    p = cyc;
    frame(0, 'h000, -1);
    wait_drain("single_drain");
    chk("arb_lat", acc_cyc[0] - p, 1);
    chk("single_burst", acc_cyc[7] - acc_cyc[0], 7);
    chk("done_lat", done_cyc - acc_cyc[7], 2);
    acc_cyc.delete();
    frame(1, 'h400, -1);
    n = 0;
    while (acc_cyc.size() < 6 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("midrst_reach", n < 100, 1);
    RESET = 1'b0;
    q0.delete();
    q1.delete();
    exp_d.delete();
    exp_t.delete();
    stg_cyc.delete();
    #1 chk("midrst_out", {OUT_VALID, FRAME_DONE, STAGE_EN, REQ0_READY, REQ1_READY}, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    acc_cyc.delete();
    frame(0, 'h300, -1);
    frame(1, 'h310, -1);
    wait_drain("midrst_drain");
`ifdef F_SCHED_TIMEOUT_EN
    acc_cyc.delete();
    q0.push_back('h501);
    q0.push_back('h502);
    exp_d.push_back(DW'('h501));
    exp_d.push_back(DW'('h502));
    exp_t.push_back({1'b0, IW'(0), 1'b0});
    exp_t.push_back({1'b0, IW'(1), 1'b0});
    n = 0;
    while (acc_cyc.size() < 2 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("to_reach", n < 100, 1);
    frame(1, 'h510, -1);
    wait_drain("to_drain");
    chk("abort_lat", abort_cyc - acc_cyc[1], 16);
`endif
    chk("abort_count", aborts, EXP_ABORTS);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
